// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU and an iterative
// shift-add multiplier / restoring divider that stalls the pipeline while it runs.
module exe_stage #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       EXE_CMD,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] ST_value_in,
  input  logic [1:0]       val1_sel,
  input  logic [1:0]       val2_sel,
  input  logic [1:0]       st_sel,
  input  logic [WIDTH-1:0] MEM_fwd,
  input  logic [WIDTH-1:0] WB_fwd,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] ST_value_out,
  output logic             stall,
  output logic             busy
);

  localparam int CW = $clog2(ITER);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_SLT  = 4'b0001;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0100;
  localparam logic [3:0] CMD_OR   = 4'b0101;
  localparam logic [3:0] CMD_NOR  = 4'b0110;
  localparam logic [3:0] CMD_XOR  = 4'b0111;
  localparam logic [3:0] CMD_SLL  = 4'b1000;
  localparam logic [3:0] CMD_SRA  = 4'b1001;
  localparam logic [3:0] CMD_SRL  = 4'b1010;
  localparam logic [3:0] CMD_MUL  = 4'b1011;
  localparam logic [3:0] CMD_DIVU = 4'b1100;
  localparam logic [3:0] CMD_REMU = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_cmd;
  logic [WIDTH-1:0] r_opA, r_opB, r_acc;

  logic [WIDTH-1:0] w_op1, w_op2, w_alu, w_mcResult;
  logic [WIDTH-1:0] w_mulSum, w_trial;
  logic [WIDTH:0]   w_shifted;
  logic             w_ge, w_isMulti, w_stall;

  // Select 11 is unused by the hazard unit and falls back to the ID/EXE value.
  always_comb begin
    w_op1        = val1;
    w_op2        = val2;
    ST_value_out = ST_value_in;
    case (val1_sel)
      2'b01:   w_op1 = MEM_fwd;
      2'b10:   w_op1 = WB_fwd;
      default: w_op1 = val1;
    endcase
    case (val2_sel)
      2'b01:   w_op2 = MEM_fwd;
      2'b10:   w_op2 = WB_fwd;
      default: w_op2 = val2;
    endcase
    case (st_sel)
      2'b01:   ST_value_out = MEM_fwd;
      2'b10:   ST_value_out = WB_fwd;
      default: ST_value_out = ST_value_in;
    endcase
  end

  always_comb begin
    w_alu = w_op1;
    case (EXE_CMD)
      CMD_ADD: w_alu = w_op1 + w_op2;
      CMD_SUB: w_alu = w_op1 - w_op2;
      CMD_AND: w_alu = w_op1 & w_op2;
      CMD_OR:  w_alu = w_op1 | w_op2;
      CMD_NOR: w_alu = ~(w_op1 | w_op2);
      CMD_XOR: w_alu = w_op1 ^ w_op2;
      CMD_SLL: w_alu = w_op1 << w_op2[SW-1:0];
      CMD_SRA: w_alu = $signed(w_op1) >>> w_op2[SW-1:0];
      CMD_SRL: w_alu = w_op1 >> w_op2[SW-1:0];
      CMD_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
      default: w_alu = w_op1;
    endcase
  end

  assign w_isMulti = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIVU) || (EXE_CMD == CMD_REMU);

  // One iteration of each algorithm. For divide, r_opA holds the dividend and
  // collects quotient bits; a zero divisor always "fits", giving all-ones / dividend.
  assign w_mulSum  = r_acc + (r_opA[0] ? r_opB : '0);
  assign w_shifted = {r_acc, r_opA[WIDTH-1]};
  assign w_ge      = (w_shifted >= {1'b0, r_opB});
  assign w_trial   = w_shifted[WIDTH-1:0] - r_opB;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_isMulti) begin
          w_stall = 1'b1;
          w_next  = BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == CW'(ITER - 1)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_cmd <= '0;
      r_opA <= '0;
      r_opB <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_isMulti) begin
            r_cmd <= EXE_CMD;
            r_opA <= w_op1;
            r_opB <= w_op2;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cmd == CMD_MUL) begin
            r_acc <= w_mulSum;
            r_opA <= r_opA >> 1;
            r_opB <= r_opB << 1;
          end else begin
            r_acc <= w_ge ? w_trial : w_shifted[WIDTH-1:0];
            r_opA <= {r_opA[WIDTH-2:0], w_ge};
          end
        end
        default: ;
      endcase
    end
  end

  assign w_mcResult = (r_cmd == CMD_DIVU) ? r_opA : r_acc;

  // EXE/MEM loads a bubble while stalled, so the result is forced to zero.
  always_comb begin
    ALU_result = w_alu;
    if (w_stall)              ALU_result = '0;
    else if (r_state == DONE) ALU_result = w_mcResult;
  end

  assign stall = w_stall;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed plan items plus random ALU and
// multi-cycle operations compared against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic [31:0] val1, val2, ST_value_in, MEM_fwd, WB_fwd;
  logic [1:0]  val1_sel, val2_sel, st_sel;
  logic [31:0] ALU_result, ST_value_out;
  logic        stall, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .val1(val1), .val2(val2),
    .ST_value_in(ST_value_in), .val1_sel(val1_sel), .val2_sel(val2_sel),
    .st_sel(st_sel), .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd),
    .ALU_result(ALU_result), .ST_value_out(ST_value_out),
    .stall(stall), .busy(busy)
  );

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] v,
                                      input logic [31:0] mem, input logic [31:0] wb);
    if (sel == 2'd1) return mem;
    if (sel == 2'd2) return wb;
    return v;
  endfunction

  function automatic logic [31:0] aluRef(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (cmd)
      4'd0:  r = a + b;
      4'd2:  r = a - b;
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = ~(a | b);
      4'd7:  r = a ^ b;
      4'd8:  r = a << b[4:0];
      4'd9:  r = $signed(a) >>> b[4:0];
      4'd10: r = a >> b[4:0];
      4'd1:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: r = a * b;
      4'd12: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: r = (b == 0) ? a : a % b;
      default: r = a;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                               input logic [31:0] st, input logic [1:0] s1, input logic [1:0] s2,
                               input logic [1:0] ss, input logic [31:0] mem, input logic [31:0] wb);
    EXE_CMD = cmd; val1 = v1; val2 = v2; ST_value_in = st;
    val1_sel = s1; val2_sel = s2; st_sel = ss; MEM_fwd = mem; WB_fwd = wb;
    #1;
  endtask

  // Checks a single-cycle op against the model, then advances one cycle.
  task automatic checkOutput(input string tag);
    logic [31:0] a, b;
    a = fwd(val1_sel, val1, MEM_fwd, WB_fwd);
    b = fwd(val2_sel, val2, MEM_fwd, WB_fwd);
    check({tag, "_res"}, ALU_result, aluRef(EXE_CMD, a, b));
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_st"}, ST_value_out, fwd(st_sel, ST_value_in, MEM_fwd, WB_fwd));
    step();
  endtask

  // Starts a multi-cycle op in the current (IDLE) cycle, scrambles the forward
  // buses while it runs, then checks stall length and the DONE-cycle result.
  task automatic runMulti(input string tag, input logic [3:0] cmd, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [1:0] s1, input logic [31:0] mem);
    logic [31:0] exp;
    int n;
    applyStimulus(cmd, v1, v2, $urandom, s1, 2'd0, 2'd0, mem, $urandom);
    exp = aluRef(cmd, fwd(s1, v1, MEM_fwd, WB_fwd), v2);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      step();
      MEM_fwd = $urandom;
      WB_fwd  = $urandom;
      #1;
    end
    check({tag, "_stallLen"}, 32'(n), 32'd33);
    check({tag, "_result"}, ALU_result, exp);
    check({tag, "_busyDone"}, {31'd0, busy}, 32'd1);
    step();
    check({tag, "_idleAfter"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] singles [13];
    logic [3:0] multis [3];
    logic [31:0] b;
    singles = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd1, 4'd3, 4'd14, 4'd15};
    multis  = '{4'd11, 4'd12, 4'd13};

    rst = 1'b1;
    applyStimulus(4'd0, 32'd3, 32'd4, 32'd9, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_alu", ALU_result, 32'd7);
    rst = 1'b0;
    step();

    applyStimulus(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    check("sweep_add", ALU_result, 32'h8000_0000);
    checkOutput("sweep_add_m");
    applyStimulus(4'd2, 32'h7FFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    check("sweep_sub", ALU_result, 32'h7FFF_FFFE);
    checkOutput("sweep_sub_m");
    applyStimulus(4'd1, 32'h7FFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    check("sweep_slt", ALU_result, 32'd0);
    checkOutput("sweep_slt_m");
    applyStimulus(4'd9, 32'h8000_0000, 32'd4, 32'd0, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    check("sweep_sra", ALU_result, 32'hF800_0000);
    checkOutput("sweep_sra_m");

    applyStimulus(4'd0, 32'd5, 32'd1, 32'd7, 2'd1, 2'd0, 2'd0, 32'd100, 32'd200);
    check("fwd_mem", ALU_result, 32'd101);
    step();
    applyStimulus(4'd0, 32'd5, 32'd1, 32'd7, 2'd2, 2'd0, 2'd0, 32'd100, 32'd200);
    check("fwd_wb", ALU_result, 32'd201);
    step();
    applyStimulus(4'd0, 32'd5, 32'd1, 32'd7, 2'd3, 2'd0, 2'd1, 32'd100, 32'd200);
    check("fwd_sel11", ALU_result, 32'd6);
    check("fwd_st", ST_value_out, 32'd100);
    step();

    runMulti("mul_dir", 4'd11, 32'hDEAD_BEEF, 32'h0002_0005, 2'd1, 32'h0001_0003);
    runMulti("divu_dir", 4'd12, 32'd100, 32'd7, 2'd0, 32'd0);
    runMulti("remu_dir", 4'd13, 32'd100, 32'd7, 2'd0, 32'd0);
    runMulti("divu_zero", 4'd12, 32'd9, 32'd0, 2'd0, 32'd0);
    runMulti("remu_zero", 4'd13, 32'd9, 32'd0, 2'd0, 32'd0);

    runMulti("b2b_first", 4'd11, 32'h0001_0003, 32'h0002_0005, 2'd0, 32'd0);
    runMulti("b2b_second", 4'd11, 32'h1234_5678, 32'h9ABC_DEF1, 2'd0, 32'd0);

    applyStimulus(4'd12, 32'd1000, 32'd3, 32'd0, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 11; i++) step();
    check("rstmid_busyBefore", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    applyStimulus(4'd0, 32'd2, 32'd3, 32'd0, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    check("rstmid_add", ALU_result, 32'd5);
    step();
    check("rstmid_add_next", ALU_result, 32'd5);
    check("rstmid_stall_next", {31'd0, stall}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(singles[$urandom_range(0, 12)], $urandom, $urandom, $urandom,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), $urandom, $urandom);
      checkOutput("rand_alu");
    end

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 1000);
        default: b = $urandom;
      endcase
      runMulti("rand_multi", multis[$urandom_range(0, 2)], $urandom, b,
               2'($urandom_range(0, 3)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
